// File: rtl/pair_scan_pkg.sv
// Shared definitions for the pair lookup array scan controller.
// Holds the array geometry, the empty-entry marker, the counter widths,
// the FSM state encoding and a helper that converts an inclusive address
// range into an entry count.
package pair_scan_pkg;

    localparam int          PORTS     = 8;
    localparam int          DEPTH     = 256;
    localparam int          ADDR_W    = 8;
    localparam int          DATA_W    = 8;
    localparam logic [7:0]  EMPTY_VAL = 8'd1;

    // 9 bits hold 0..256 and 7 bits hold 0..64, so accumulators never wrap.
    localparam int          CNT_W     = 9;
    localparam int          QCNT_W    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Inclusive range length; end < start wraps through 255 -> 0, and
    // start == end + 1 (mod 256) yields the full 256-entry sweep.
    function automatic logic [CNT_W-1:0] rangeLen(
        input logic [ADDR_W-1:0] startAddr,
        input logic [ADDR_W-1:0] endAddr
    );
        logic [ADDR_W-1:0] span;
        span = endAddr - startAddr;
        return CNT_W'(span) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pair_scan_if.sv
// Bundle of the host handshake, the result outputs and the eight-lane
// array address/data buses seen by pair_scan_controller.
//   slave  : the controller (takes start/range/data_bus, drives the rest)
//   master : host logic plus the array (drives start/range/data_bus)
interface pair_scan_if;
    import pair_scan_pkg::*;

    logic                      start;
    logic [ADDR_W-1:0]         start_addr;
    logic [ADDR_W-1:0]         end_addr;
    logic [PORTS*ADDR_W-1:0]   addr_bus;
    logic [PORTS*DATA_W-1:0]   data_bus;
    logic                      busy;
    logic                      done;
    logic [CNT_W-1:0]          pair_count;
    logic [QCNT_W-1:0]         quad_count0;
    logic [QCNT_W-1:0]         quad_count1;
    logic [QCNT_W-1:0]         quad_count2;
    logic [QCNT_W-1:0]         quad_count3;
    logic [ADDR_W-1:0]         first_addr;
    logic                      found;

    modport slave (
        input  start, start_addr, end_addr, data_bus,
        output addr_bus, busy, done, pair_count,
               quad_count0, quad_count1, quad_count2, quad_count3,
               first_addr, found
    );

    modport master (
        output start, start_addr, end_addr, data_bus,
        input  addr_bus, busy, done, pair_count,
               quad_count0, quad_count1, quad_count2, quad_count3,
               first_addr, found
    );

endinterface

// File: rtl/pair_scan_controller_lane_tally.sv
// Combinational tally of one registered beat.
// Ports:
//   laneData  in  registered array data, one byte per lane
//   laneVld   in  lane-valid mask for the beat
//   laneAddr  in  address each lane was reading
//   total     out occupied lanes in the beat (0..PORTS)
//   quadPop   out occupied lanes per quadrant addr[MSB:MSB-1]
//   anyOcc    out at least one lane occupied
//   firstLane out lowest occupied lane index
module lane_tally #(
    parameter int         PORTS     = 8,
    parameter int         AW        = 8,
    parameter int         DW        = 8,
    parameter logic [7:0] EMPTY_VAL = 8'd1
) (
    input  logic [PORTS-1:0][DW-1:0]          laneData,
    input  logic [PORTS-1:0]                  laneVld,
    input  logic [PORTS-1:0][AW-1:0]          laneAddr,
    output logic [$clog2(PORTS+1)-1:0]        total,
    output logic [3:0][$clog2(PORTS+1)-1:0]   quadPop,
    output logic                              anyOcc,
    output logic [$clog2(PORTS)-1:0]          firstLane
);
    import pair_scan_pkg::*;

    localparam int LW  = $clog2(PORTS + 1);
    localparam int LIW = $clog2(PORTS);

    logic [PORTS-1:0] occ;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            occ[i] = laneVld[i] && (laneData[i] != DW'(EMPTY_VAL));
        end
    end

    always_comb begin
        total     = '0;
        quadPop   = '0;
        anyOcc    = 1'b0;
        firstLane = '0;
        // Walk from the top lane down so the lowest occupied lane is the
        // last one to write firstLane.
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (occ[i]) begin
                total     = total + LW'(1);
                anyOcc    = 1'b1;
                firstLane = LIW'(i);
                for (int q = 0; q < 4; q++) begin
                    if (laneAddr[i][AW-1 -: 2] == 2'(q)) begin
                        quadPop[q] = quadPop[q] + LW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pair_scan_controller.sv
// Scan sequencer for the eight-port 256x8 pair lookup array.
// On an accepted start it sweeps [start_addr, end_addr] (inclusive, with
// wrap), issuing PORTS reads per cycle, then reports the occupied-entry
// count, per-quadrant counts and the first occupied address.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-low; clears all state
//   bus    slave side of pair_scan_if (start, range, addr/data buses,
//          busy, done and the result outputs)
module pair_scan_controller #(
    parameter int         PORTS     = pair_scan_pkg::PORTS,
    parameter int         DEPTH     = pair_scan_pkg::DEPTH,
    parameter logic [7:0] EMPTY_VAL = pair_scan_pkg::EMPTY_VAL
) (
    input  logic        clk,
    input  logic        reset,
    pair_scan_if.slave  bus
);
    import pair_scan_pkg::*;

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = $clog2(PORTS + 1);
    localparam int LIW = $clog2(PORTS);

    state_t                      state;
    state_t                      nextState;
    logic [AW-1:0]               ptr;
    logic [CNT_W-1:0]            remaining;
    logic                        accept;
    logic                        lastBeat;

    logic [PORTS-1:0][AW-1:0]    laneAddr_p0;
    logic [PORTS-1:0]            vld_p0;
    logic [PORTS*AW-1:0]         addrBus;

    logic [PORTS-1:0][DATA_W-1:0] laneData_p1;
    logic [PORTS-1:0][AW-1:0]    laneAddr_p1;
    logic [PORTS-1:0]            vld_p1;

    logic [LW-1:0]               beatTotal;
    logic [3:0][LW-1:0]          beatQuad;
    logic                        beatAny;
    logic [LIW-1:0]              beatFirst;

    logic [CNT_W-1:0]            pairCount;
    logic [3:0][QCNT_W-1:0]      quadCount;
    logic [AW-1:0]               firstAddr;
    logic                        found;

    assign accept   = ((state == IDLE) || (state == DONE)) && bus.start;
    assign lastBeat = (remaining <= CNT_W'(PORTS));

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (bus.start) nextState = ISSUE;
            ISSUE:   if (lastBeat)  nextState = DRAIN;
            DRAIN:   nextState = DONE;
            DONE:    nextState = bus.start ? ISSUE : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Issue stage: lane addresses and valid mask for the current beat.
    // Lanes past the end of the range are masked and park at address 0.
    always_comb begin
        addrBus = '0;
        for (int i = 0; i < PORTS; i++) begin
            laneAddr_p0[i] = ptr + AW'(i);
            vld_p0[i]      = (state == ISSUE) && (CNT_W'(i) < remaining);
            if (vld_p0[i]) begin
                addrBus[i*AW +: AW] = laneAddr_p0[i];
            end
        end
    end

    assign bus.addr_bus = addrBus;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            vld_p1    <= '0;
            pairCount <= '0;
            quadCount <= '0;
            firstAddr <= '0;
            found     <= 1'b0;
        end else begin
            state  <= nextState;
            vld_p1 <= vld_p0;
            if (accept) begin
                ptr       <= bus.start_addr;
                remaining <= rangeLen(bus.start_addr, bus.end_addr);
                pairCount <= '0;
                quadCount <= '0;
                firstAddr <= '0;
                found     <= 1'b0;
            end else begin
                if (state == ISSUE) begin
                    ptr       <= ptr + AW'(PORTS);
                    remaining <= lastBeat ? '0 : remaining - CNT_W'(PORTS);
                end
                // Accumulate stage: tally of the beat registered last edge.
                pairCount <= pairCount + CNT_W'(beatTotal);
                for (int q = 0; q < 4; q++) begin
                    quadCount[q] <= quadCount[q] + QCNT_W'(beatQuad[q]);
                end
                if (!found && beatAny) begin
                    found     <= 1'b1;
                    firstAddr <= laneAddr_p1[beatFirst];
                end
            end
        end
    end

    // Beat register: data and addresses need no reset, vld_p1 gates them.
    always_ff @(posedge clk) begin
        laneData_p1 <= bus.data_bus;
        laneAddr_p1 <= laneAddr_p0;
    end

    lane_tally #(
        .PORTS     (PORTS),
        .AW        (AW),
        .DW        (DATA_W),
        .EMPTY_VAL (EMPTY_VAL)
    ) u_tally (
        .laneData  (laneData_p1),
        .laneVld   (vld_p1),
        .laneAddr  (laneAddr_p1),
        .total     (beatTotal),
        .quadPop   (beatQuad),
        .anyOcc    (beatAny),
        .firstLane (beatFirst)
    );

    assign bus.busy        = (state == ISSUE) || (state == DRAIN);
    assign bus.done        = (state == DONE);
    assign bus.pair_count  = pairCount;
    assign bus.quad_count0 = quadCount[0];
    assign bus.quad_count1 = quadCount[1];
    assign bus.quad_count2 = quadCount[2];
    assign bus.quad_count3 = quadCount[3];
    assign bus.first_addr  = firstAddr;
    assign bus.found       = found;

endmodule

// File: tb/tb_pair_scan_controller.sv
// Directed bench for pair_scan_controller against a behavioural array
// holding the standard pair table: occupied entries 3,4,6, 8..28, 64..90,
// 128..150 and 192..210 (24/27/23/19 per quadrant, 93 total); all others
// hold the empty marker 8'h01.
module tb_pair_scan_controller;

    logic clk;
    logic reset;
    logic [7:0] mem [256];

    int vecCount  = 0;
    int missCount = 0;

    pair_scan_if ifc ();

    pair_scan_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array read ports: combinational from the address lanes.
    always_comb begin
        ifc.data_bus = '0;
        for (int i = 0; i < 8; i++) begin
            ifc.data_bus[i*8 +: 8] = mem[ifc.addr_bus[i*8 +: 8]];
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input int pc, input int q0,
                               input int q1, input int q2, input int q3,
                               input int fa, input int fd);
        checkVal({tag, "_pair"},  64'(ifc.pair_count),  64'(pc));
        checkVal({tag, "_q0"},    64'(ifc.quad_count0), 64'(q0));
        checkVal({tag, "_q1"},    64'(ifc.quad_count1), 64'(q1));
        checkVal({tag, "_q2"},    64'(ifc.quad_count2), 64'(q2));
        checkVal({tag, "_q3"},    64'(ifc.quad_count3), 64'(q3));
        checkVal({tag, "_first"}, 64'(ifc.first_addr),  64'(fa));
        checkVal({tag, "_found"}, 64'(ifc.found),       64'(fd));
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_busy"}, 64'(ifc.busy), 64'(0));
        checkVal({tag, "_done"}, 64'(ifc.done), 64'(0));
        checkVal({tag, "_addr"}, ifc.addr_bus, 64'(0));
        checkResult(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called #1 after a posedge at cycle count 'from'; returns the number of
    // cycles from the accept edge to the done cycle.
    task automatic waitDone(input int from, output int lat);
        lat = from;
        while (!ifc.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ifc.done) checkVal("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic runScan(input logic [7:0] sa, input logic [7:0] ea,
                           output int lat, output logic [63:0] beat0);
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.start_addr = sa;
        ifc.end_addr   = ea;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        beat0 = ifc.addr_bus;
        checkVal("busy_after_accept", 64'(ifc.busy), 64'(1));
        waitDone(1, lat);
    endtask

    initial begin
        int          lat;
        int          doneCnt;
        logic [63:0] beat0;
        logic        occ;

        for (int a = 0; a < 256; a++) begin
            occ = (a == 3) || (a == 4) || (a == 6) || (a >= 8 && a <= 28) ||
                  (a >= 64 && a <= 90) || (a >= 128 && a <= 150) ||
                  (a >= 192 && a <= 210);
            // Some occupied entries hold 8'h00 so only EMPTY_VAL means empty.
            mem[a] = occ ? ((a % 4 == 0) ? 8'h00 : (8'(a) ^ 8'hA5)) : 8'h01;
        end

        reset          = 1'b0;
        ifc.start      = 1'b1;
        ifc.start_addr = 8'd0;
        ifc.end_addr   = 8'd255;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        ifc.start = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        checkVal("idle_busy", 64'(ifc.busy), 64'(0));

        // Full sweep
        runScan(8'd0, 8'd255, lat, beat0);
        checkVal("full_lat", 64'(lat), 64'(34));
        checkVal("full_beat0", beat0, 64'h0706050403020100);
        checkResult("full", 93, 24, 27, 23, 19, 3, 1);
        checkVal("full_busy_at_done", 64'(ifc.busy), 64'(0));

        // Single beat 0..7
        runScan(8'd0, 8'd7, lat, beat0);
        checkVal("p07_lat", 64'(lat), 64'(3));
        checkResult("p07", 3, 3, 0, 0, 0, 3, 1);

        // Wrap within one beat 252..3
        runScan(8'd252, 8'd3, lat, beat0);
        checkVal("wrap_lat", 64'(lat), 64'(3));
        checkVal("wrap_beat0", beat0, 64'h03020100FFFEFDFC);
        checkResult("wrap", 1, 1, 0, 0, 0, 3, 1);

        // Single empty entry
        runScan(8'd5, 8'd5, lat, beat0);
        checkVal("s5_lat", 64'(lat), 64'(3));
        checkResult("s5", 0, 0, 0, 0, 0, 0, 0);

        // Single occupied entry: only lane 0 addresses anything
        runScan(8'd3, 8'd3, lat, beat0);
        checkVal("s3_beat0", beat0, 64'h0000000000000003);
        checkResult("s3", 1, 1, 0, 0, 0, 3, 1);

        // Two beats 20..35
        runScan(8'd20, 8'd35, lat, beat0);
        checkVal("r2035_lat", 64'(lat), 64'(4));
        checkResult("r2035", 9, 9, 0, 0, 0, 20, 1);

        // Wrapping range with a partial final beat: 250..70, L = 77
        runScan(8'd250, 8'd70, lat, beat0);
        checkVal("r25070_lat", 64'(lat), 64'(12));
        checkResult("r25070", 31, 24, 7, 0, 0, 3, 1);

        // Start pulsed mid-ISSUE is ignored
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.start_addr = 8'd0;
        ifc.end_addr   = 8'd255;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge clk); #1;
            lat++;
        end
        ifc.start    = 1'b1;
        ifc.end_addr = 8'd7;
        @(posedge clk); #1;
        lat++;
        ifc.start = 1'b0;
        waitDone(lat, lat);
        checkVal("ign_lat", 64'(lat), 64'(34));
        checkResult("ign", 93, 24, 27, 23, 19, 3, 1);
        doneCnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ifc.done) doneCnt++;
        end
        checkVal("ign_extra_done", 64'(doneCnt), 64'(0));
        checkVal("ign_hold_pair", 64'(ifc.pair_count), 64'(93));

        // Back-to-back with start held through done
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.start_addr = 8'd0;
        ifc.end_addr   = 8'd255;
        @(posedge clk); #1;
        waitDone(1, lat);
        checkVal("b2b_lat1", 64'(lat), 64'(34));
        checkVal("b2b_pair1", 64'(ifc.pair_count), 64'(93));
        @(posedge clk); #1;
        ifc.start = 1'b0;
        checkVal("b2b_busy", 64'(ifc.busy), 64'(1));
        checkVal("b2b_done_low", 64'(ifc.done), 64'(0));
        checkVal("b2b_cleared", 64'(ifc.pair_count), 64'(0));
        waitDone(1, lat);
        checkVal("b2b_lat2", 64'(lat), 64'(34));
        checkResult("b2b", 93, 24, 27, 23, 19, 3, 1);

        // Reset asserted at beat 10 of a full sweep
        @(negedge clk);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkVal("mid_busy_before", 64'(ifc.busy), 64'(1));
        reset     = 1'b0;
        ifc.start = 1'b1;
        @(posedge clk); #1;
        checkResetState("midrst");
        @(posedge clk); #1;
        reset     = 1'b1;
        ifc.start = 1'b0;
        @(posedge clk); #1;
        checkVal("midrst_start_ignored", 64'(ifc.busy), 64'(0));
        doneCnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ifc.done) doneCnt++;
        end
        checkVal("midrst_no_done", 64'(doneCnt), 64'(0));

        runScan(8'd0, 8'd255, lat, beat0);
        checkVal("rescan_lat", 64'(lat), 64'(34));
        checkResult("rescan", 93, 24, 27, 23, 19, 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
